// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: default mode,
// counter width and the bundle of timing flags carried by the delay line.
package vga_pkg;

    localparam int CNT_W     = 13;
    localparam int MAX_TOTAL = 8192;

    // 1600x1200@60, 162 MHz pixel clock
    localparam int DEF_H_ACTIVE = 1600;
    localparam int DEF_H_FP     = 64;
    localparam int DEF_H_SYNC   = 192;
    localparam int DEF_H_BP     = 304;
    localparam int DEF_V_ACTIVE = 1200;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 46;

    localparam logic DEF_H_POL = 1'b1;
    localparam logic DEF_V_POL = 1'b1;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } vga_timing_t;

    // Blanking value of the timing flags for a given sync polarity.
    function automatic vga_timing_t idle_timing(logic h_pol, logic v_pol);
        vga_timing_t t;
        t.active = 1'b0;
        t.hsync  = ~h_pol;
        t.vsync  = ~v_pol;
        return t;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register for the timing flags, so the pins can be
// aligned with a registered pixel pipeline. Depth 0 is a plain wire.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int          DEPTH = 1,
    parameter vga_timing_t IDLE  = '0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  vga_timing_t din,
    output vga_timing_t dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = CLK ^ RST_N;
        assign dout = din;
    end else begin : g_pipe
        vga_timing_t stages [DEPTH];

        // Shift one stage per clock; reset flushes every stage to blanking.
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                for (int i = 0; i < DEPTH; i++) stages[i] <= IDLE;
            end else begin
                stages[0] <= din;
                for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
            end
        end

        assign dout = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters with registered
// ACTIVE/sync/start decodes, plus delayed copies of the timing flags.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic H_POL      = DEF_H_POL,
    parameter logic V_POL      = DEF_V_POL,
    parameter int   PIPE_DELAY = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             ACTIVE,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             LINE_START,
    output logic             FRAME_START,
    output logic             ACTIVE_D,
    output logic             HSYNC_D,
    output logic             VSYNC_D
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    localparam vga_timing_t IDLE = idle_timing(H_POL, V_POL);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $fatal(1, "vga_timing: H_TOTAL/V_TOTAL exceed 13-bit counter range");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
        $fatal(1, "vga_timing: PIPE_DELAY must be 0..15");
    end

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             active_nxt;
    logic             hsync_on;
    logic             vsync_on;

    // Next raster position; wrap is by compare so no overflow is relied on.
    always_comb begin
        h_nxt = h + ONE;
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + ONE;
        end
    end

    // Decodes use the next position so they land in the same cycle as h/v.
    always_comb begin
        active_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
        hsync_on   = (int'(h_nxt) >= H_SYNC_BEG) && (int'(h_nxt) < H_SYNC_END);
        vsync_on   = (int'(v_nxt) >= V_SYNC_BEG) && (int'(v_nxt) < V_SYNC_END);
    end

    // Counter and decode registers; reset parks on the last blanking pixel
    // so the first released edge presents pixel (0, 0).
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            h           <= H_LAST;
            v           <= V_LAST;
            ACTIVE      <= 1'b0;
            HSYNC       <= ~H_POL;
            VSYNC       <= ~V_POL;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            h           <= h_nxt;
            v           <= v_nxt;
            ACTIVE      <= active_nxt;
            HSYNC       <= hsync_on ? H_POL : ~H_POL;
            VSYNC       <= vsync_on ? V_POL : ~V_POL;
            LINE_START  <= (h_nxt == '0);
            FRAME_START <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    vga_timing_t timing_now;
    vga_timing_t timing_dly;

    assign timing_now.active = ACTIVE;
    assign timing_now.hsync  = HSYNC;
    assign timing_now.vsync  = VSYNC;

    vga_delay_line #(
        .DEPTH (PIPE_DELAY),
        .IDLE  (IDLE)
    ) u_delay (
        .CLK   (CLK),
        .RST_N (RST_N),
        .din   (timing_now),
        .dout  (timing_dly)
    );

    assign ACTIVE_D = timing_dly.active;
    assign HSYNC_D  = timing_dly.hsync;
    assign VSYNC_D  = timing_dly.vsync;

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the VGA output path. Produces the pixel coordinates `h`/`v`, the `ACTIVE` flag and `HSYNC`/`VSYNC` that the draw stage consumes. It also produces pipeline-delayed copies of `ACTIVE`/`HSYNC`/`VSYNC`, so the pins stay aligned with the draw stage's registered pixel data. It sits between the pixel-clock source and the draw stage.

## Interface

**Parameters** (defaults are the 1600x1200@60 mode at a 162 MHz pixel clock)
- `H_ACTIVE`, 1600: visible pixels per line
- `H_FP`, 64: horizontal front porch, in clocks
- `H_SYNC`, 192: horizontal sync width, in clocks
- `H_BP`, 304: horizontal back porch, in clocks
- `V_ACTIVE`, 1200: visible lines per frame
- `V_FP`, 1: vertical front porch, in lines
- `V_SYNC`, 3: vertical sync width, in lines
- `V_BP`, 46: vertical back porch, in lines
- `H_POL`, 1: `HSYNC` asserted level
- `V_POL`, 1: `VSYNC` asserted level
- `PIPE_DELAY`, 1: clocks of delay on the `_D` outputs, legal range 0..15

**Ports**
- `CLK`  in  1  pixel clock
- `RST_N`  in  1  reset, synchronous, active-low
- `h`  out  13  horizontal count, 0..H_TOTAL-1
- `v`  out  13  vertical count, 0..V_TOTAL-1
- `ACTIVE`  out  1  high when `h < H_ACTIVE && v < V_ACTIVE`
- `HSYNC`  out  1  horizontal sync, at polarity `H_POL`
- `VSYNC`  out  1  vertical sync, at polarity `V_POL`
- `LINE_START`  out  1  one-cycle pulse when `h == 0`
- `FRAME_START`  out  1  one-cycle pulse when `h == 0 && v == 0`
- `ACTIVE_D`, `HSYNC_D`, `VSYNC_D`  out  1 each  `ACTIVE`/`HSYNC`/`VSYNC` delayed by `PIPE_DELAY` clocks

## Operation

**Derived constants**
- `H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP`, 2160 by default.
- `V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP`, 1250 by default.
- Both totals must be ≤ 8192. Elaboration fails otherwise.

**Counters**
- `h` increments every clock.
- At `h == H_TOTAL-1`, `h` wraps to 0 and `v` advances.
- At `v == V_TOTAL-1` with `h == H_TOTAL-1`, `v` wraps to 0.
- Arithmetic is unsigned 13-bit. Wrap happens on compare, never on overflow.

**Sync windows**
- `HSYNC` is asserted for `H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC`.
- `VSYNC` is asserted for whole lines with `V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC`. Its edges coincide with `h == 0`.

**Output alignment**
- All outputs are registered.
- `ACTIVE`, `HSYNC`, `VSYNC`, `LINE_START` and `FRAME_START` always describe the `h`/`v` value presented in the same cycle. Decodes are computed from the next-count value.

**Delay line**
- Shift register of depth `PIPE_DELAY`.
- `PIPE_DELAY = 0`: the `_D` outputs equal the undelayed outputs combinationally.

**Reset (while `RST_N` is low at a clock edge)**
- `h = H_TOTAL-1` (2159) and `v = V_TOTAL-1` (1249), i.e. the last blanking pixel of the frame.
- `ACTIVE = 0`, `LINE_START = 0`, `FRAME_START = 0`.
- `HSYNC = !H_POL`, `VSYNC = !V_POL`.
- All delay-line stages hold the inactive values: `ACTIVE` 0, syncs deasserted.
- These values are consistent with the decode of position (2159, 1249).
- First edge with `RST_N` high: `h = 0`, `v = 0`, `ACTIVE = 1`, `FRAME_START = 1`.

**Reset mid-frame**
- Takes effect at the next edge and discards the current frame.
- Any sync pulse truncates immediately. The short pulse is acceptable.
- The delay line flushes to inactive.

**No handshake**
- The block free-runs. Downstream samples it every clock.

## Timing

- Latency from reset release to the first visible pixel: 1 clock.
- Line period: `H_TOTAL` clocks. Frame period: `H_TOTAL*V_TOTAL` clocks, 2,700,000 by default.
- `HSYNC` asserts at `h = 1664` and deasserts at `h = 1856`.
- `VSYNC` asserts at `(h, v) = (0, 1201)` and deasserts at `(0, 1204)`.
- The draw stage updates its image position on the `VSYNC` falling edge. That edge lands in vertical back porch, 46 lines before the next active line.
- `_D` outputs lag their source by exactly `PIPE_DELAY` edges, including across frame wrap.

## Structure

- Package `vga_pkg` holds:
  - the default mode constants (H/V active, porch, sync and polarity values);
  - the counter width, 13;
  - a `vga_timing_t` struct `{active, hsync, vsync}` used by the delay line.
- Sub-module `vga_delay_line`: parameterised depth, carries `vga_timing_t`, has a synchronous active-low reset to the inactive value, and depth 0 is a pass-through.
- Counter and decode logic live in the top module.

## Test plan

- **Reset release:** hold `RST_N` low 5 clocks, then release.
  - During reset: `h = 2159`, `v = 1249`, `ACTIVE = 0`, `HSYNC = 0`, `VSYNC = 0`.
  - First edge after release: (0, 0), `ACTIVE = 1`, `FRAME_START = 1`.
- **Horizontal timing over one full line:**
  - `ACTIVE` is high for exactly 1600 clocks.
  - `HSYNC` is high from h = 1664 to 1855 (192 clocks).
  - `LINE_START` pulses once every 2160 clocks.
- **Full frame:**
  - `VSYNC` is high for 3×2160 clocks, starting at (0, 1201).
  - `FRAME_START` repeats every 2,700,000 clocks.
  - `v` wraps from 1249 to 0.
- **Small mode and inverted polarity:** `H_*` = 8/2/3/2, `V_*` = 4/1/2/1, `H_POL = 0`, `V_POL = 0`.
  - `H_TOTAL = 15`, `V_TOTAL = 8`.
  - `HSYNC` is low at h = 10..12.
  - `VSYNC` is low at v = 5..6.
- **`PIPE_DELAY` 0, 1 and 3:** each `_D` output equals its source shifted by exactly 0, 1 or 3 clocks across a frame wrap.
- **Mid-sync reset:** assert `RST_N` low at (1700, 1202).
  - Next edge: `HSYNC`, `VSYNC` and all `_D` outputs are inactive, and counters read (2159, 1249).
  - Restart matches the reset-release scenario.
